// File: rtl/wire_pkg.sv
// wire_pkg
// Shared definitions for the wireframe pipeline (vertex projector,
// edge sequencer, line drawer).
//   - default coordinate / vertex-index / edge-index widths
//   - edge sequencer state encoding
//   - clip outcode bit positions
package wire_pkg;

    localparam int WIRE_COORD_W = 10;
    localparam int WIRE_VIDX_W  = 3;
    localparam int WIRE_EIDX_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_E_RD,
        S_E_LAT,
        S_A_LAT,
        S_B_LAT,
        S_DRAW,
        S_GAP,
        S_NEXT
    } seq_state_t;

    localparam int OC_LEFT   = 0;
    localparam int OC_RIGHT  = 1;
    localparam int OC_TOP    = 2;
    localparam int OC_BOTTOM = 3;

    typedef logic [3:0] outcode_t;

endpackage

// File: rtl/clip_outcode.sv
// clip_outcode
// Combinational Cohen-Sutherland style region code for one projected point.
// Ports:
//   x, y     in  COORD_W signed : point coordinates
//   outcode  out 4              : bit OC_LEFT   x < 0
//                                 bit OC_RIGHT  x >= SCREEN_W
//                                 bit OC_TOP    y < 0
//                                 bit OC_BOTTOM y >= SCREEN_H
module clip_outcode
    import wire_pkg::*;
#(
    parameter int COORD_W  = WIRE_COORD_W,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic signed [COORD_W-1:0] x,
    input  logic signed [COORD_W-1:0] y,
    output outcode_t                  outcode
);

    // Screen limits expressed at coordinate width so the compares stay signed.
    localparam logic signed [COORD_W-1:0] LIMIT_X = COORD_W'(SCREEN_W);
    localparam logic signed [COORD_W-1:0] LIMIT_Y = COORD_W'(SCREEN_H);

    // A negative coordinate is simply one with its sign bit set.
    always_comb begin
        outcode            = '0;
        outcode[OC_LEFT]   = x[COORD_W-1];
        outcode[OC_RIGHT]  = (x >= LIMIT_X);
        outcode[OC_TOP]    = y[COORD_W-1];
        outcode[OC_BOTTOM] = (y >= LIMIT_Y);
    end

endmodule

// File: rtl/wire_edge_sequencer.sv
// wire_edge_sequencer
// Walks the wireframe edge list once per frame, fetches both projected
// endpoints of each edge from the vertex table and hands them to the
// Bresenham line drawer one edge at a time.
//
// Configuration macro: WIRE_CLIP_REJECT_EN
//   defined   : edges whose endpoints are both off the same screen side are
//               skipped (no line_en pulse)
//   undefined : every edge is drawn; SCREEN_W/SCREEN_H unused
//
// Ports:
//   clock, resetn          clock / async active-low reset
//   start                  one-cycle frame start request (ignored when busy)
//   busy                   frame in progress
//   frame_done             one-cycle pulse in NEXT of the last edge
//   edge_addr              edge list read address
//   edge_a, edge_b         edge endpoint indices (1-cycle read latency)
//   vert_addr              vertex table read address
//   vert_x, vert_y         projected vertex coordinates (1-cycle latency)
//   line_en                line drawer enable
//   x0, y0, x1, y1         line endpoints, stable while line_en is high
//   line_done              line drawer finished
//   edge_idx               index of the edge in flight
module wire_edge_sequencer
    import wire_pkg::*;
#(
    parameter int COORD_W   = WIRE_COORD_W,
    parameter int VIDX_W    = WIRE_VIDX_W,
    parameter int EIDX_W    = WIRE_EIDX_W,
    parameter int NUM_EDGES = 12,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      start,
    output logic                      busy,
    output logic                      frame_done,
    output logic [EIDX_W-1:0]         edge_addr,
    input  logic [VIDX_W-1:0]         edge_a,
    input  logic [VIDX_W-1:0]         edge_b,
    output logic [VIDX_W-1:0]         vert_addr,
    input  logic signed [COORD_W-1:0] vert_x,
    input  logic signed [COORD_W-1:0] vert_y,
    output logic                      line_en,
    output logic signed [COORD_W-1:0] x0,
    output logic signed [COORD_W-1:0] y0,
    output logic signed [COORD_W-1:0] x1,
    output logic signed [COORD_W-1:0] y1,
    input  logic                      line_done,
    output logic [EIDX_W-1:0]         edge_idx
);

    localparam logic [EIDX_W-1:0] LAST_EDGE = EIDX_W'(NUM_EDGES - 1);

    seq_state_t          state;
    logic [EIDX_W-1:0]   edge_count;
    logic [VIDX_W-1:0]   vert_b;
    logic                last_edge;
    logic                reject;

    assign last_edge = (edge_count == LAST_EDGE);
    assign edge_addr = edge_count;
    assign edge_idx  = edge_count;

`ifdef WIRE_CLIP_REJECT_EN
    outcode_t outcode0;
    outcode_t outcode1;

    // Endpoint 0 is already registered in x0/y0 by B_LAT; endpoint 1 is
    // judged straight off the vertex read data that x1/y1 are about to latch.
    clip_outcode #(
        .COORD_W  (COORD_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clip0 (
        .x       (x0),
        .y       (y0),
        .outcode (outcode0)
    );

    clip_outcode #(
        .COORD_W  (COORD_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clip1 (
        .x       (vert_x),
        .y       (vert_y),
        .outcode (outcode1)
    );

    assign reject = |(outcode0 & outcode1);
`else
    localparam int unused_screen_dims = SCREEN_W + SCREEN_H;

    assign reject = 1'b0;
`endif

    // The vertex read address has to follow edge_a in the same cycle the edge
    // data arrives, so it is decoded from state rather than registered; this
    // lets A_LAT and B_LAT each see their vertex one cycle later.
    always_comb begin
        vert_addr = '0;
        case (state)
            S_E_LAT: vert_addr = edge_a;
            S_A_LAT: vert_addr = vert_b;
            default: vert_addr = '0;
        endcase
    end

    // Main sequencer. Endpoints only change in A_LAT/B_LAT, so they are stable
    // for the whole time line_en is high. GAP forces one low enable cycle so
    // the negative-edge drawer re-arms between edges.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            edge_count <= '0;
            vert_b     <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            line_en    <= 1'b0;
            x0         <= '0;
            y0         <= '0;
            x1         <= '0;
            y1         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    frame_done <= 1'b0;
                    if (start) begin
                        edge_count <= '0;
                        busy       <= 1'b1;
                        state      <= S_E_RD;
                    end
                end
                S_E_RD: begin
                    state <= S_E_LAT;
                end
                S_E_LAT: begin
                    vert_b <= edge_b;
                    state  <= S_A_LAT;
                end
                S_A_LAT: begin
                    x0    <= vert_x;
                    y0    <= vert_y;
                    state <= S_B_LAT;
                end
                S_B_LAT: begin
                    x1 <= vert_x;
                    y1 <= vert_y;
                    if (reject) begin
                        frame_done <= last_edge;
                        state      <= S_NEXT;
                    end else begin
                        line_en <= 1'b1;
                        state   <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (line_done) begin
                        line_en <= 1'b0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    frame_done <= last_edge;
                    state      <= S_NEXT;
                end
                S_NEXT: begin
                    frame_done <= 1'b0;
                    if (last_edge) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        edge_count <= edge_count + 1'b1;
                        state      <= S_E_RD;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    line_en <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wire_edge_sequencer.sv
// tb_wire_edge_sequencer
// Self-checking bench for wire_edge_sequencer: edge/vertex memory models,
// a line drawer model (line_done 3 cycles into line_en), a negedge monitor
// collecting each drawn line, and a frame-level reference model.
// Honours WIRE_CLIP_REJECT_EN the same way the design does.
module tb_wire_edge_sequencer;
    import wire_pkg::*;

    localparam int COORD_W   = 10;
    localparam int NUM_EDGES = 12;
    localparam int DRAW_LEN  = 3;
`ifdef WIRE_CLIP_REJECT_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    typedef struct {
        int idx;
        int x0;
        int y0;
        int x1;
        int y1;
    } rec_t;

    logic                      clock = 1'b0;
    logic                      resetn;
    logic                      start;
    logic                      busy;
    logic                      frame_done;
    logic [3:0]                edge_addr;
    logic [2:0]                edge_a;
    logic [2:0]                edge_b;
    logic [2:0]                vert_addr;
    logic signed [COORD_W-1:0] vert_x;
    logic signed [COORD_W-1:0] vert_y;
    logic                      line_en;
    logic signed [COORD_W-1:0] x0;
    logic signed [COORD_W-1:0] y0;
    logic signed [COORD_W-1:0] x1;
    logic signed [COORD_W-1:0] y1;
    logic                      line_done = 1'b0;
    logic [3:0]                edge_idx;

    logic [2:0]                ea_tab [16];
    logic [2:0]                eb_tab [16];
    logic signed [COORD_W-1:0] vx_tab [8];
    logic signed [COORD_W-1:0] vy_tab [8];

    int checks = 0;
    int errors = 0;

    int   done_hold = 0;
    int   en_cnt    = 0;
    int   hold_left = 0;

    rec_t got_q [$];
    rec_t exp_q [$];
    int   len_q [$];
    int   exp_busy;
    int   fd_cnt;
    int   busy_cycles;
    int   stab_err;
    int   min_gap;
    int   low_run;
    int   cur_len;
    bit   prev_en;
    bit   seen_pulse;
    logic [4*COORD_W-1:0] snap;

    wire_edge_sequencer dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .edge_addr  (edge_addr),
        .edge_a     (edge_a),
        .edge_b     (edge_b),
        .vert_addr  (vert_addr),
        .vert_x     (vert_x),
        .vert_y     (vert_y),
        .line_en    (line_en),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .line_done  (line_done),
        .edge_idx   (edge_idx)
    );

    always #5 clock = ~clock;

    // Synchronous-read edge list and vertex table.
    always @(posedge clock) begin
        edge_a <= ea_tab[edge_addr];
        edge_b <= eb_tab[edge_addr];
        vert_x <= vx_tab[vert_addr];
        vert_y <= vy_tab[vert_addr];
    end

    // Line drawer model: done after DRAW_LEN enabled cycles, optionally
    // lingering done_hold cycles after enable drops.
    always @(negedge clock) begin
        if (line_en) begin
            en_cnt++;
            if (en_cnt >= DRAW_LEN) begin
                line_done = 1'b1;
                hold_left = done_hold;
            end
        end else begin
            en_cnt = 0;
            if (hold_left > 0) hold_left--;
            else line_done = 1'b0;
        end
    end

    // Monitor: one record per line_en pulse, pulse lengths, gaps, stability.
    always @(negedge clock) begin
        if (line_en) begin
            if (!prev_en) begin
                if (seen_pulse && low_run < min_gap) min_gap = low_run;
                seen_pulse = 1'b1;
                cur_len    = 1;
                got_q.push_back('{int'(edge_idx), int'(x0), int'(y0), int'(x1), int'(y1)});
                snap = {x0, y0, x1, y1};
            end else begin
                cur_len++;
                if ({x0, y0, x1, y1} !== snap) stab_err++;
            end
            low_run = 0;
        end else begin
            if (prev_en) len_q.push_back(cur_len);
            low_run++;
        end
        if (busy === 1'b1) busy_cycles++;
        if (frame_done === 1'b1) fd_cnt++;
        prev_en = line_en;
    end

    task automatic check_output(input string tag, input logic signed [31:0] obs,
                                input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit off_same_side(int ax, int ay, int bx, int by);
        return (ax < 0 && bx < 0) || (ax >= 160 && bx >= 160) ||
               (ay < 0 && by < 0) || (ay >= 120 && by >= 120);
    endfunction

    // Reference: per edge, look up both endpoints; clipped edges cost the 5
    // overhead cycles, drawn edges add GAP and the drawer's busy time.
    task automatic build_expected();
        rec_t r;
        exp_q.delete();
        exp_busy = 0;
        for (int e = 0; e < NUM_EDGES; e++) begin
            r.idx = e;
            r.x0  = vx_tab[ea_tab[e]];
            r.y0  = vy_tab[ea_tab[e]];
            r.x1  = vx_tab[eb_tab[e]];
            r.y1  = vy_tab[eb_tab[e]];
            if (CLIP_ON && off_same_side(r.x0, r.y0, r.x1, r.y1)) begin
                exp_busy += 5;
            end else begin
                exp_q.push_back(r);
                exp_busy += 6 + DRAW_LEN;
            end
        end
    endtask

    task automatic clear_monitor();
        @(posedge clock);
        #1;
        got_q.delete();
        len_q.delete();
        fd_cnt      = 0;
        busy_cycles = 0;
        stab_err    = 0;
        min_gap     = 1000;
        low_run     = 0;
        seen_pulse  = 1'b0;
        prev_en     = line_en;
    endtask

    task automatic start_frame();
        clear_monitor();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (busy === 1'b0 && fd_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clock);
        check_output({tag, ".finished"}, ok, 1);
    endtask

    task automatic wait_line_en(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (line_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check_output({tag, ".line_en_seen"}, ok, 1);
    endtask

    task automatic apply_stimulus(input string tag);
        start_frame();
        wait_frame(tag);
    endtask

    task automatic check_frame(input string tag);
        int n;
        int mx;
        build_expected();
        check_output({tag, ".pulses"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_output($sformatf("%s.l%0d.idx", tag, i), got_q[i].idx, exp_q[i].idx);
            check_output($sformatf("%s.l%0d.x0", tag, i), got_q[i].x0, exp_q[i].x0);
            check_output($sformatf("%s.l%0d.y0", tag, i), got_q[i].y0, exp_q[i].y0);
            check_output($sformatf("%s.l%0d.x1", tag, i), got_q[i].x1, exp_q[i].x1);
            check_output($sformatf("%s.l%0d.y1", tag, i), got_q[i].y1, exp_q[i].y1);
        end
        mx = 0;
        foreach (len_q[i]) if (len_q[i] > mx) mx = len_q[i];
        check_output({tag, ".frame_done_cnt"}, fd_cnt, 1);
        check_output({tag, ".busy_after"}, busy, 0);
        check_output({tag, ".busy_cycles"}, busy_cycles, exp_busy);
        check_output({tag, ".stability"}, stab_err, 0);
        check_output({tag, ".len_cnt"}, len_q.size(), exp_q.size());
        check_output({tag, ".max_len"}, mx, (exp_q.size() > 0) ? DRAW_LEN : 0);
        check_output({tag, ".gap_ge6"}, min_gap >= 6, 1);
    endtask

    task automatic load_cube();
        int ca [12] = '{0, 1, 3, 2, 4, 5, 7, 6, 0, 1, 2, 3};
        int cb [12] = '{1, 3, 2, 0, 5, 7, 6, 4, 4, 5, 6, 7};
        for (int v = 0; v < 8; v++) begin
            vx_tab[v] = COORD_W'($urandom_range(10, 150));
            vy_tab[v] = COORD_W'($urandom_range(10, 110));
        end
        for (int e = 0; e < 16; e++) begin
            ea_tab[e] = (e < 12) ? 3'(ca[e]) : 3'd0;
            eb_tab[e] = (e < 12) ? 3'(cb[e]) : 3'd0;
        end
    endtask

    initial begin
        int lat;
        resetn = 1'b0;
        start  = 1'b0;
        for (int e = 0; e < 16; e++) begin
            ea_tab[e] = '0;
            eb_tab[e] = '0;
        end
        for (int v = 0; v < 8; v++) begin
            vx_tab[v] = '0;
            vy_tab[v] = '0;
        end

        // Reset state
        #12;
        check_output("rst.busy", busy, 0);
        check_output("rst.frame_done", frame_done, 0);
        check_output("rst.line_en", line_en, 0);
        check_output("rst.edge_addr", edge_addr, 0);
        check_output("rst.vert_addr", vert_addr, 0);
        check_output("rst.edge_idx", edge_idx, 0);
        check_output("rst.x0", x0, 0);
        check_output("rst.y0", y0, 0);
        check_output("rst.x1", x1, 0);
        check_output("rst.y1", y1, 0);
        @(posedge clock);
        #1 resetn = 1'b1;

        // Cube frame with start-to-enable latency check
        $display("[TB] cube frame");
        load_cube();
        start_frame();
        check_output("cube.busy_rise", busy, 1);
        check_output("cube.edge_idx0", edge_idx, 0);
        lat = 0;
        for (int c = 0; c < 20 && line_en !== 1'b1; c++) begin
            @(negedge clock);
            lat++;
        end
        check_output("cube.en_latency", lat, 4);
        wait_frame("cube");
        check_frame("cube");

        // Random frames
        for (int r = 0; r < 3; r++) begin
            $display("[TB] random frame %0d", r);
            for (int v = 0; v < 8; v++) begin
                vx_tab[v] = COORD_W'(int'($urandom_range(0, 400)) - 200);
                vy_tab[v] = COORD_W'(int'($urandom_range(0, 400)) - 200);
            end
            for (int e = 0; e < 16; e++) begin
                ea_tab[e] = 3'($urandom_range(0, 7));
                eb_tab[e] = 3'($urandom_range(0, 7));
            end
            apply_stimulus($sformatf("rand%0d", r));
            check_frame($sformatf("rand%0d", r));
        end

        // Degenerate edge (2,2), vertex 2 = (5,7)
        $display("[TB] degenerate edge");
        vx_tab[2] = 10'sd5;
        vy_tab[2] = 10'sd7;
        for (int e = 0; e < 16; e++) begin
            ea_tab[e] = 3'd2;
            eb_tab[e] = 3'd2;
        end
        apply_stimulus("degen");
        check_frame("degen");
        if (got_q.size() > 0) begin
            check_output("degen.x0", got_q[0].x0, 5);
            check_output("degen.y0", got_q[0].y0, 7);
            check_output("degen.x1", got_q[0].x1, 5);
            check_output("degen.y1", got_q[0].y1, 7);
        end

        // Off-screen edge followed by a full-diagonal edge on the boundary
        $display("[TB] off-screen edge");
        vx_tab[0] = -10'sd10; vy_tab[0] = 10'sd5;
        vx_tab[1] = -10'sd3;  vy_tab[1] = 10'sd40;
        vx_tab[2] = 10'sd0;   vy_tab[2] = 10'sd0;
        vx_tab[3] = 10'sd159; vy_tab[3] = 10'sd119;
        ea_tab[0] = 3'd0;
        eb_tab[0] = 3'd1;
        for (int e = 1; e < 16; e++) begin
            ea_tab[e] = 3'd2;
            eb_tab[e] = 3'd3;
        end
        apply_stimulus("clip");
        check_frame("clip");
        check_output("clip.pulses_direct", got_q.size(), CLIP_ON ? 11 : 12);
        if (got_q.size() > 0) begin
            check_output("clip.first_x0", got_q[0].x0, CLIP_ON ? 0 : -10);
            check_output("clip.first_idx", got_q[0].idx, CLIP_ON ? 1 : 0);
        end

        // start pulsed during DRAW is ignored
        $display("[TB] start during draw");
        load_cube();
        start_frame();
        wait_line_en("sdraw");
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_frame("sdraw");
        check_frame("sdraw");

        // Reset during DRAW, then restart from edge 0
        $display("[TB] reset during draw");
        start_frame();
        wait_line_en("rdraw");
        #3 resetn = 1'b0;
        #1;
        check_output("rdraw.line_en", line_en, 0);
        check_output("rdraw.busy", busy, 0);
        check_output("rdraw.edge_idx", edge_idx, 0);
        check_output("rdraw.x0", x0, 0);
        @(posedge clock);
        #1 resetn = 1'b1;
        start_frame();
        check_output("rdraw.restart_idx", edge_idx, 0);
        wait_frame("rdraw");
        check_frame("rdraw");

        // line_done held for 5 cycles: no duplicate edge
        $display("[TB] long line_done");
        done_hold = 4;
        apply_stimulus("hold");
        check_frame("hold");
        done_hold = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wire_edge_sequencer.md
# wire_edge_sequencer

Walks the wireframe edge list for one frame, fetches both projected endpoints of each edge from the vertex table and drives the Bresenham line drawer one edge at a time. Sits directly upstream of the line drawer: owns its `line_en` and endpoint inputs and consumes its `line_done`. The per-object renderer starts it once per frame, after vertex projection has filled the vertex table.

## Interface
Parameters:
- `COORD_W`, default 10: signed two's-complement coordinate width, matching the line drawer.
- `VIDX_W`, default 3: vertex index width.
- `EIDX_W`, default 4: edge index width.
- `NUM_EDGES`, default 12: edges per frame, 1..2^EIDX_W.
- `SCREEN_W`, default 160: visible width, used only for clip reject.
- `SCREEN_H`, default 120: visible height, used only for clip reject.

Ports:
- `clock` in 1: rising-edge clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle pulse; begins a frame when idle.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse after the last edge completes.
- `edge_addr` out EIDX_W: edge list read address.
- `edge_a`, `edge_b` in VIDX_W each: endpoint vertex indices, valid 1 cycle after `edge_addr`.
- `vert_addr` out VIDX_W: vertex table read address.
- `vert_x`, `vert_y` in COORD_W each: projected coordinates, valid 1 cycle after `vert_addr`.
- `line_en` out 1: enable to the line drawer.
- `x0`, `y0`, `x1`, `y1` out COORD_W each: endpoints to the line drawer.
- `line_done` in 1: line drawer finished; stays high while `line_en` is held.
- `edge_idx` out EIDX_W: index of the edge being processed (debug/status).

## Operation
- States: IDLE, E_RD, E_LAT, A_LAT, B_LAT, DRAW, GAP, NEXT.
- IDLE: `start` → E_RD with edge counter cleared to 0.
- E_RD: `edge_addr` = counter → E_LAT.
- E_LAT:
  - Latch `edge_a`/`edge_b`.
  - Drive `vert_addr` = a → A_LAT.
- A_LAT:
  - Latch `vert_x`/`vert_y` into `x0`/`y0`.
  - Drive `vert_addr` = b → B_LAT.
- B_LAT: latch into `x1`/`y1` → DRAW, or → NEXT if clip-rejected (see Configuration).
- DRAW:
  - `line_en` = 1.
  - On `line_done` = 1 → GAP.
- GAP:
  - `line_en` = 0 for exactly one cycle, so the drawer (negative-edge clocked) sees enable low and re-arms.
  - → NEXT.
- NEXT:
  - If counter == NUM_EDGES-1: pulse `frame_done` and → IDLE.
  - Else: increment counter → E_RD.
- Endpoints `x0`..`y1` must remain stable whenever `line_en` = 1. They change only in A_LAT/B_LAT.
- `edge_a == edge_b` (degenerate edge) is passed through unchanged; the drawer plots a single point.
- `start` while `busy` is ignored.
- `line_done` outside DRAW is ignored.
- Coordinates are passed through untouched; no arithmetic except the clip compare.
- Reset values: state IDLE; `busy`, `frame_done`, `line_en` = 0; `edge_addr`, `vert_addr`, `edge_idx`, `x0`..`y1` = 0.
- Reset mid-frame: outputs return to reset values immediately (asynchronous); no partial frame resumes.

## Timing
- `busy` = 1 in every state except IDLE; it rises the cycle after `start`.
- Per-edge overhead outside DRAW: 5 cycles (E_RD, E_LAT, A_LAT, B_LAT, NEXT) plus GAP when drawn.
- `line_en` rises 4 cycles after entering E_RD.
- `line_en` falls the cycle after `line_done` is sampled high.
- `frame_done` is asserted during NEXT of the last edge; `busy` falls in the same cycle it returns to IDLE.
- `edge_idx` = counter, registered, valid from E_RD.

## Configuration
- Macro `WIRE_CLIP_REJECT_EN`.
- Defined: in B_LAT, compute a 4-bit outcode per endpoint:
  - left: x<0
  - right: x≥SCREEN_W
  - top: y<0
  - bottom: y≥SCREEN_H
  - Compares are signed.
  - If `outcode0 & outcode1` ≠ 0, skip DRAW/GAP and go to NEXT; `line_en` never rises for that edge.
- Not defined: every edge is drawn; the SCREEN_W/SCREEN_H parameters are unused.

## Structure
- Shared package `wire_pkg`:
  - State enum.
  - Outcode bit positions.
  - Default COORD_W/VIDX_W/EIDX_W constants shared with the line drawer and vertex projector.
- One sub-module, `clip_outcode`: combinational, coordinate pair → 4-bit outcode. Instantiated twice, only under `WIRE_CLIP_REJECT_EN`.

## Test plan
- Cube, 12 edges; drawer model asserts `line_done` 3 cycles after `line_en`:
  - exactly 12 `line_en` pulses;
  - each pulse separated by ≥1 low cycle;
  - endpoints match the table;
  - one `frame_done`; `busy` low afterwards.
- Edge (2,2) with vertex 2 = (5,7) → `x0`=`x1`=5, `y0`=`y1`=7, one pulse.
- `WIRE_CLIP_REJECT_EN` defined, edge (-10,5)→(-3,40) → no `line_en`; next edge (0,0)→(159,119) is drawn.
- Same off-screen edge with the macro undefined → drawn with `x0`=-10 (0x3F6).
- `start` pulsed during DRAW → ignored. `resetn` low during DRAW → `line_en`/`busy` drop at once. Re-start → edge_idx begins at 0.
- `line_done` held high for 5 cycles → `line_en` falls after the first, with no duplicate edge.
